// File: rtl/clut_pkg.sv
// Shared CLUT definitions: colour width, default index width
// and the palette loader state encoding.
package clut_pkg;

  localparam int COLRW     = 12;
  localparam int CIDXW_DEF = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    B0   = 2'd1,
    B1   = 2'd2,
    B2   = 2'd3
  } ld_state_e;

endpackage

// File: rtl/palette_loader_if.sv
// Palette loader bus: load request, byte stream handshake,
// CLUT write port and status.
interface palette_loader_if
  import clut_pkg::*;
#(
  parameter int CIDXW = CIDXW_DEF
) ();

  logic             start;
  logic [CIDXW-1:0] start_idx;
  logic [CIDXW:0]   count;
  logic [7:0]       in_data;
  logic             in_valid;
  logic             in_ready;
  logic             we;
  logic [CIDXW-1:0] cidx_write;
  logic [COLRW-1:0] colr_in;
  logic             busy;
  logic             done;

  modport master (
    output start, start_idx, count,
    output in_data, in_valid,
    input  in_ready,
    input  we, cidx_write, colr_in,
    input  busy, done
  );

  modport slave (
    input  start, start_idx, count,
    input  in_data, in_valid,
    output in_ready,
    output we, cidx_write, colr_in,
    output busy, done
  );

endinterface

// File: rtl/palette_loader.sv
// Unpacks a 3-bytes-per-2-colours stream into CLUT writes,
// starting at start_idx and wrapping the index.
module palette_loader
  import clut_pkg::*;
#(
  parameter int CIDXW = CIDXW_DEF
) (
  input  logic             clk,
  input  logic             rst,
  palette_loader_if.slave  bus
);

  localparam logic [CIDXW:0] REM_ONE = 1;

  ld_state_e        state, state_n;
  logic [CIDXW-1:0] idx, idx_n;
  logic [CIDXW:0]   rem, rem_n;
  logic [7:0]       a_hi, a_hi_n;
  logic [3:0]       b_hi, b_hi_n;
  logic             we_q, we_n;
  logic [CIDXW-1:0] cidx_q, cidx_n;
  logic [COLRW-1:0] colr_q, colr_n;
  logic             done_q, done_n;
  logic             acc;

  assign bus.in_ready   = (state != IDLE);
  assign bus.busy       = (state != IDLE);
  assign bus.we         = we_q;
  assign bus.cidx_write = cidx_q;
  assign bus.colr_in    = colr_q;
  assign bus.done       = done_q;

  assign acc = bus.in_valid && (state != IDLE);

  // Next state, byte unpacking and write generation
  always_comb begin
    state_n = state;
    idx_n   = idx;
    rem_n   = rem;
    a_hi_n  = a_hi;
    b_hi_n  = b_hi;
    we_n    = 1'b0;
    cidx_n  = cidx_q;
    colr_n  = colr_q;
    done_n  = 1'b0;
    unique case (state)
      IDLE: begin
        if (bus.start) begin
          if (bus.count == '0) begin
            done_n = 1'b1;
          end else begin
            state_n = B0;
            idx_n   = bus.start_idx;
            rem_n   = bus.count;
          end
        end
      end
      B0: begin
        if (acc) begin
          a_hi_n  = bus.in_data;
          state_n = B1;
        end
      end
      B1: begin
        if (acc) begin
          we_n   = 1'b1;
          cidx_n = idx;
          colr_n = {a_hi, bus.in_data[7:4]};
          b_hi_n = bus.in_data[3:0];
          idx_n  = idx + 1'b1;
          rem_n  = rem - 1'b1;
          if (rem == REM_ONE) begin
            state_n = IDLE;
            done_n  = 1'b1;
          end else begin
            state_n = B2;
          end
        end
      end
      B2: begin
        if (acc) begin
          we_n   = 1'b1;
          cidx_n = idx;
          colr_n = {b_hi, bus.in_data};
          idx_n  = idx + 1'b1;
          rem_n  = rem - 1'b1;
          if (rem == REM_ONE) begin
            state_n = IDLE;
            done_n  = 1'b1;
          end else begin
            state_n = B0;
          end
        end
      end
      default: state_n = IDLE;
    endcase
  end

  // State and datapath registers with synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= IDLE;
      idx    <= '0;
      rem    <= '0;
      a_hi   <= '0;
      b_hi   <= '0;
      we_q   <= 1'b0;
      cidx_q <= '0;
      colr_q <= '0;
      done_q <= 1'b0;
    end else begin
      state  <= state_n;
      idx    <= idx_n;
      rem    <= rem_n;
      a_hi   <= a_hi_n;
      b_hi   <= b_hi_n;
      we_q   <= we_n;
      cidx_q <= cidx_n;
      colr_q <= colr_n;
      done_q <= done_n;
    end
  end

endmodule

// File: tb/tb_palette_loader.sv
// Randomised scoreboard bench for palette_loader:
// colour lists are packed into bytes, writes checked in order.
module tb_palette_loader;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   failures = 0;

  typedef struct {
    logic        we;
    logic [3:0]  idx;
    logic [11:0] colr;
    logic        done;
  } ev_t;

  ev_t         exp_q[$];
  logic [11:0] fix[2];
  bit          use_fix = 0;
  logic [3:0]  last_idx = '0;
  logic [11:0] last_colr = '0;

  palette_loader_if #(.CIDXW(4)) bus ();

  palette_loader #(.CIDXW(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  // Monitor: every write or done pulse must match the queue head
  always @(negedge clk) begin
    if (bus.we || bus.done) begin
      checks++;
      if (exp_q.size() == 0) begin
        failures++;
        $display("FAIL unexpected_event we=%0b idx=%0d colr=%h done=%0b",
                 bus.we, bus.cidx_write, bus.colr_in, bus.done);
      end else begin
        ev_t e;
        e = exp_q.pop_front();
        if (bus.we !== e.we || bus.done !== e.done ||
            (e.we && (bus.cidx_write !== e.idx ||
                      bus.colr_in !== e.colr))) begin
          failures++;
          $display("FAIL event got we=%0b idx=%0d colr=%h done=%0b exp we=%0b idx=%0d colr=%h done=%0b",
                   bus.we, bus.cidx_write, bus.colr_in, bus.done,
                   e.we, e.idx, e.colr, e.done);
        end
      end
    end
    if (rst) begin
      last_idx  = '0;
      last_colr = '0;
    end else if (bus.we) begin
      last_idx  = bus.cidx_write;
      last_colr = bus.colr_in;
    end else begin
      checks++;
      if (bus.cidx_write !== last_idx || bus.colr_in !== last_colr) begin
        failures++;
        $display("FAIL hold got idx=%0d colr=%h exp idx=%0d colr=%h",
                 bus.cidx_write, bus.colr_in, last_idx, last_colr);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input int got, input int exp);
    checks++;
    if (got != exp) begin
      failures++;
      $display("FAIL %s got=%0d exp=%0d", name, got, exp);
    end
  endtask

  task automatic drain();
    int t = 0;
    while (exp_q.size() != 0 && t < 30) begin
      tick();
      t++;
    end
    check("drain_pending", exp_q.size(), 0);
  endtask

  // One load: feed < 0 feeds the whole stream
  task automatic load(input int sidx, input int cnt, input int gapmax,
                      input int feed, input bit poke, output int acc);
    logic [11:0] col[16];
    logic [7:0]  bq[$];
    logic [11:0] a, b;
    logic [3:0]  nib;
    int          nb, pos;
    bit          ok;
    int          t;
    acc = 0;
    for (int i = 0; i < cnt; i++)
      col[i] = (use_fix && i < 2) ? fix[i] : 12'($urandom);
    for (int p = 0; 2 * p < cnt; p++) begin
      a = col[2*p];
      bq.push_back(a[11:4]);
      if (2 * p + 1 < cnt) begin
        b = col[2*p+1];
        bq.push_back({a[3:0], b[11:8]});
        bq.push_back(b[7:0]);
      end else begin
        nib = use_fix ? 4'hF : 4'($urandom);
        bq.push_back({a[3:0], nib});
      end
    end
    nb = (feed < 0) ? bq.size() : feed;
    for (int k = 0; k < cnt; k++) begin
      pos = 3 * (k / 2) + 1 + (k % 2);
      if (pos < nb)
        exp_q.push_back('{1'b1, 4'((sidx + k) % 16), col[k],
                          (k == cnt - 1)});
    end
    if (cnt == 0)
      exp_q.push_back('{1'b0, 4'd0, 12'd0, 1'b1});
    bus.start     = 1'b1;
    bus.start_idx = 4'(sidx);
    bus.count     = 5'(cnt);
    tick();
    bus.start     = 1'b0;
    bus.start_idx = 4'($urandom);
    bus.count     = 5'($urandom_range(0, 16));
    if (cnt == 0) begin
      check("zero_done", int'(bus.done), 1);
      check("zero_busy", int'(bus.busy), 0);
      tick();
      check("zero_done_end", int'(bus.done), 0);
      check("zero_busy_end", int'(bus.busy), 0);
    end
    for (int j = 0; j < nb; j++) begin
      if (poke && j == 1) begin
        bus.start = 1'b1;
        bus.count = 5'($urandom_range(0, 16));
        tick();
        bus.start = 1'b0;
      end
      repeat ($urandom_range(0, gapmax)) begin
        bus.in_valid = 1'b0;
        bus.in_data  = 8'($urandom);
        tick();
      end
      bus.in_valid = 1'b1;
      bus.in_data  = bq[j];
      t = 0;
      do begin
        ok = bus.in_ready;
        tick();
        t++;
      end while (!ok && t < 50);
      if (!ok) begin
        failures++;
        $display("FAIL byte_timeout byte=%0d", j);
      end else begin
        acc++;
      end
      bus.in_valid = 1'b0;
    end
    if (feed < 0) begin
      drain();
      check("end_ready", int'(bus.in_ready), 0);
      check("end_busy", int'(bus.busy), 0);
    end
  endtask

  initial begin
    int acc;
    bus.start     = 1'b0;
    bus.start_idx = '0;
    bus.count     = '0;
    bus.in_data   = '0;
    bus.in_valid  = 1'b0;
    repeat (3) tick();
    check("rst_outputs",
          int'({bus.we, bus.done, bus.busy, bus.in_ready,
                bus.cidx_write, bus.colr_in}), 0);
    rst = 1'b0;
    tick();

    use_fix = 1;
    fix[0] = 12'hF08;
    fix[1] = 12'hABC;
    load(2, 2, 0, -1, 0, acc);
    check("two_bytes", acc, 3);

    fix[0] = 12'h123;
    load($urandom_range(0, 15), 1, 0, -1, 0, acc);
    check("odd_bytes", acc, 2);
    use_fix = 0;
    bus.in_valid = 1'b1;
    bus.in_data  = 8'h55;
    for (int i = 0; i < 3; i++) begin
      check("extra_ready", int'(bus.in_ready), 0);
      tick();
    end
    bus.in_valid = 1'b0;

    load(15, 2, 1, -1, 0, acc);
    check("wrap_bytes", acc, 3);

    load($urandom_range(0, 15), 16, 3, -1, 1, acc);
    check("full_bytes", acc, 24);

    load($urandom_range(0, 15), 0, 0, -1, 0, acc);

    load($urandom_range(0, 15), 4, 1, 2, 0, acc);
    rst = 1'b1;
    tick();
    check("abort_outputs",
          int'({bus.we, bus.done, bus.busy, bus.in_ready,
                bus.cidx_write, bus.colr_in}), 0);
    rst = 1'b0;
    bus.in_valid = 1'b1;
    repeat (4) tick();
    bus.in_valid = 1'b0;
    check("abort_pending", exp_q.size(), 0);

    for (int n = 0; n < 12; n++) begin
      int c;
      c = $urandom_range(0, 16);
      load($urandom_range(0, 15), c, 3, -1, 1'($urandom), acc);
      check("rand_bytes", acc, (3 * c + 1) / 2);
    end

    repeat (3) tick();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/palette_loader.md
PALETTE_LOADER -- requirements
Module: palette_loader

Interface
REQ-001 SHALL have parameter CIDXW, default 4, colour index width; colour width is fixed at 12 bits (COLRW from the shared package).
REQ-002 SHALL have port clk  input  1  single clock, all logic on rising edge.
REQ-003 SHALL have port rst  input  1  reset, synchronous and active-high.
REQ-004 SHALL have port start  input  1  one-cycle load request, sampled only in IDLE.
REQ-005 SHALL have port start_idx  input  CIDXW  first palette index to write.
REQ-006 SHALL have port count  input  CIDXW+1  number of colours to load, 0..2^CIDXW.
REQ-007 SHALL have port in_data  input  8  packed palette byte stream.
REQ-008 SHALL have port in_valid  input  1  in_data valid.
REQ-009 SHALL have port in_ready  output  1  loader accepts a byte this cycle.
REQ-010 SHALL have port we  output  1  CLUT write enable, drives clut_simple we.
REQ-011 SHALL have port cidx_write  output  CIDXW  CLUT write index.
REQ-012 SHALL have port colr_in  output  12  CLUT write colour.
REQ-013 SHALL have port busy  output  1  load in progress.
REQ-014 SHALL have port done  output  1  one-cycle pulse at load completion.

Function
REQ-015 SHALL implement FSM states IDLE, B0, B1, B2; IDLE->B0 on start with count!=0; B0->B1->B2->B0 on each accepted byte, until the load ends.
REQ-016 SHALL accept a byte on the rising edge where in_valid and in_ready are both 1.
REQ-017 SHALL drive in_ready combinationally as (state!=IDLE); in_ready SHALL NOT depend on in_valid.
REQ-018 SHALL unpack two colours per 3 bytes: B0 = A[11:4]; B1 = {A[3:0], B[11:8]}; B2 = B[7:0].
REQ-019 SHALL register we=1 for exactly one cycle, together with colr_in and cidx_write, on the edge that accepts B1 (colour A) and on the edge that accepts B2 (colour B).
REQ-020 SHALL write the first colour to start_idx and increment the index by 1 per write, wrapping modulo 2^CIDXW.
REQ-021 SHALL decrement a remaining-colours counter on each write; the load ends on the write that reaches zero.
REQ-022 SHALL ignore B1[3:0] when count is odd and the final colour is A; the load then ends after B1 and no B2 is consumed.
REQ-023 SHALL, on the final write edge, return to IDLE, deassert busy and pulse done in the same cycle as the final we.
REQ-024 SHALL, for start with count=0, stay in IDLE, keep busy at 0 and pulse done on the next cycle with no write.
REQ-025 SHALL ignore start while busy; start_idx and count SHALL be captured only on an accepted start.
REQ-026 SHALL hold we, cidx_write and colr_in stable between writes: we=0, other two hold their last value.
REQ-027 SHALL treat count>2^CIDXW as undefined; the bench SHALL NOT drive it.

Reset
REQ-028 SHALL, on rst=1 at a clock edge, force state=IDLE, we=0, done=0, busy=0, cidx_write=0, colr_in=0 and remaining count=0.
REQ-029 SHALL, on reset mid-load, abort with no further writes and no done pulse; rst SHALL take priority over start and any byte handshake.

Structure
REQ-030 SHALL take COLRW=12, the default CIDXW and the FSM state enum from a shared package, clut_pkg.
REQ-031 SHALL be a single module with no sub-module; its outputs connect directly to the clut_simple write port on the same clock.

Verification
REQ-032 SHALL cover: start_idx=2, count=2, bytes 0xF0,0x8A,0xBC -> we at idx2 = 0xF08, then idx3 = 0xABC, done with the second we.
REQ-033 SHALL cover: count=1, bytes 0x12,0x3F -> single write 0x123, done, state IDLE, in_ready=0, third byte not accepted.
REQ-034 SHALL cover: start_idx=15, count=2, CIDXW=4 -> writes to idx15 then idx0 (wrap).
REQ-035 SHALL cover: in_valid toggled randomly, with gaps of 0..3 cycles, during a 16-colour load -> 24 bytes consumed, 16 writes, contents match the model.
REQ-036 SHALL cover: rst asserted after B1 of a 4-colour load -> no further we, no done, all outputs 0 the next cycle; a following load works normally.
REQ-037 SHALL cover: count=0 start -> done pulse one cycle later, no we, busy never 1; start pulsed while busy -> ignored.
